// File: rtl/multi_cycle_sequencer_pkg.sv
// Shared state and opcode codes for the multi-cycle sequencer.
package multi_cycle_sequencer_pkg;

  localparam int unsigned STATE_LEN = 3;
  localparam int unsigned OPCODE    = 6;

  typedef enum logic [STATE_LEN-1:0] {
    STATE_IF   = 3'd0,
    STATE_ID   = 3'd1,
    STATE_EX   = 3'd2,
    STATE_MEM  = 3'd3,
    STATE_WB   = 3'd4,
    STATE_HALT = 3'd5
  } state_e;

  localparam logic [OPCODE-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE-1:0] OP_SW    = 6'b101011;

  function automatic logic is_alu_op(input logic [OPCODE-1:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_mem_op(input logic [OPCODE-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multi_cycle_sequencer_perf_counter.sv
// Enable-gated wrapping counter used for the sequencer's performance counters.
module perf_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle CPU sequencer: IF/ID/EX/MEM/WB stepping with memory wait states and halt.
// Performance counters are built only when MC_SEQ_PERF_CNT_EN is defined.
module multi_cycle_sequencer
  import multi_cycle_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE-1:0]    opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 halt_req,
  output logic [STATE_LEN-1:0] state,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic                 halted,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retire_cnt
);

  state_e state_q, state_d;
  logic   imem_req_c, dmem_req_c, ir_write_c, pc_write_c, pc_cond_c, done_c, illegal_c;

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    ir_write_c = 1'b0;
    pc_write_c = 1'b0;
    pc_cond_c  = 1'b0;
    done_c     = 1'b0;
    illegal_c  = 1'b0;
    unique case (state_q)
      STATE_IF: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = STATE_ID;
        end
      end
      STATE_ID: begin
        if (opcode == OP_J) begin
          pc_write_c = 1'b1;
          done_c     = 1'b1;
        end else begin
          state_d = STATE_EX;
        end
      end
      STATE_EX: begin
        if (opcode == OP_BEQ) begin
          pc_cond_c = 1'b1;
          done_c    = 1'b1;
        end else if (is_alu_op(opcode)) begin
          state_d = STATE_WB;
        end else if (is_mem_op(opcode)) begin
          state_d = STATE_MEM;
        end else begin
          // Unsupported opcode retires as a NOP.
          illegal_c = 1'b1;
          done_c    = 1'b1;
        end
      end
      STATE_MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ready) begin
          if (opcode == OP_LW) state_d = STATE_WB;
          else                 done_c  = 1'b1;
        end
      end
      STATE_WB: done_c = 1'b1;
      STATE_HALT: begin
        if (!halt_req) state_d = STATE_IF;
      end
      default: state_d = STATE_IF;
    endcase
    // halt_req only matters on the ending cycle, so mid-instruction requests are deferred.
    if (done_c) state_d = halt_req ? STATE_HALT : STATE_IF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STATE_IF;
    else        state_q <= state_d;
  end

  assign state         = state_q;
  assign halted        = (state_q == STATE_HALT);
  assign imem_req      = imem_req_c & rst_n;
  assign dmem_req      = dmem_req_c & rst_n;
  assign ir_write      = ir_write_c & rst_n;
  assign pc_write      = pc_write_c & rst_n;
  assign pc_write_cond = pc_cond_c & rst_n;
  assign instr_done    = done_c & rst_n;
  assign illegal_op    = illegal_c & rst_n;

`ifdef MC_SEQ_PERF_CNT_EN
  perf_counter #(
    .Width (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (state_q != STATE_HALT),
    .count_o (cycle_cnt)
  );

  perf_counter #(
    .Width (CNT_W)
  ) u_retire_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (done_c),
    .count_o (retire_cnt)
  );
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Scoreboard bench for multi_cycle_sequencer: per-cycle expected states/strobes queued then checked.
module tb_multi_cycle_sequencer;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          imem_ready, dmem_ready, halt_req;
  logic [2:0]    state;
  logic          imem_req, dmem_req, ir_write, pc_write, pc_write_cond;
  logic          instr_done, illegal_op, halted;
  logic [CW-1:0] cycle_cnt, retire_cnt;

  always #5 clk = ~clk;

  multi_cycle_sequencer #(
    .CNT_W (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .halt_req      (halt_req),
    .state         (state),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .halted        (halted),
    .cycle_cnt     (cycle_cnt),
    .retire_cnt    (retire_cnt)
  );

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100;
  localparam logic [5:0] O_ADDI = 6'b001000, O_ORI = 6'b001101, O_LW = 6'b100011;
  localparam logic [5:0] O_SW = 6'b101011, O_BAD = 6'b111111;

  // Flag order: imem_req dmem_req ir_write pc_write pc_write_cond instr_done illegal_op halted
  localparam logic [7:0] F_IMR = 8'h80, F_DMR = 8'h40, F_IRW = 8'h20, F_PCW = 8'h10;
  localparam logic [7:0] F_PCC = 8'h08, F_DONE = 8'h04, F_ILL = 8'h02, F_HLT = 8'h01;

  typedef struct packed {
    logic        ir;
    logic        dr;
    logic        hr;
    logic [5:0]  op;
    logic [10:0] exp;
  } step_t;

  step_t       sbq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned mc = 0;
  int unsigned mr = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic ir, input logic dr, input logic hr, input logic [5:0] op,
                      input logic [2:0] st, input logic [7:0] f);
    step_t s;
    s.ir  = ir;
    s.dr  = dr;
    s.hr  = hr;
    s.op  = op;
    s.exp = {st, f};
    sbq.push_back(s);
  endtask

  // Expected per-cycle trace of one instruction; h holds halt_req from EX onward.
  task automatic build(input logic [5:0] op, input int iw, input int dw, input logic h);
    logic alu, mem;
    alu = (op == O_R) || (op == O_ADDI) || (op == O_ORI);
    mem = (op == O_LW) || (op == O_SW);
    for (int i = 0; i < iw; i++) push(1'b0, 1'b1, 1'b0, O_BAD, S_IF, F_IMR);
    push(1'b1, 1'b1, 1'b0, O_BAD, S_IF, F_IMR | F_IRW | F_PCW);
    if (op == O_J) begin
      push(1'b1, 1'b1, 1'b0, op, S_ID, F_PCW | F_DONE);
      return;
    end
    push(1'b1, 1'b1, 1'b0, op, S_ID, 8'h00);
    if (op == O_BEQ) begin
      push(1'b1, 1'b1, h, op, S_EX, F_PCC | F_DONE);
    end else if (alu) begin
      push(1'b1, 1'b1, h, op, S_EX, 8'h00);
      push(1'b1, 1'b1, h, op, S_WB, F_DONE);
    end else if (mem) begin
      push(1'b1, 1'b1, h, op, S_EX, 8'h00);
      for (int i = 0; i < dw; i++) push(1'b1, 1'b0, h, op, S_MEM, F_DMR);
      if (op == O_LW) begin
        push(1'b1, 1'b1, h, op, S_MEM, F_DMR);
        push(1'b1, 1'b1, h, op, S_WB, F_DONE);
      end else begin
        push(1'b1, 1'b1, h, op, S_MEM, F_DMR | F_DONE);
      end
    end else begin
      push(1'b1, 1'b1, h, op, S_EX, F_ILL | F_DONE);
    end
  endtask

  task automatic halt_seq(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b1, O_BAD, S_HALT, F_HLT);
    push(1'b1, 1'b1, 1'b0, O_BAD, S_HALT, F_HLT);
  endtask

  task automatic drive(input step_t s);
    imem_ready = s.ir;
    dmem_ready = s.dr;
    halt_req   = s.hr;
    opcode     = s.op;
  endtask

  task automatic check_cnt(input string tag);
    logic [CW-1:0] ec, er;
`ifdef MC_SEQ_PERF_CNT_EN
    ec = CW'(mc);
    er = CW'(mr);
`else
    ec = '0;
    er = '0;
`endif
    check_eq({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(ec));
    check_eq({tag, " retire_cnt"}, 64'(retire_cnt), 64'(er));
  endtask

  task automatic check_step(input step_t s);
    string tag;
    tag = $sformatf("op%02h st%0d", s.op, s.exp[10:8]);
    check_eq({tag, " state/strobes"},
             64'({state, imem_req, dmem_req, ir_write, pc_write, pc_write_cond,
                  instr_done, illegal_op, halted}), 64'(s.exp));
    check_cnt(tag);
  endtask

  // Pops up to n steps; entered and left at 1 time unit after a rising edge.
  task automatic run(input int n);
    step_t s;
    for (int i = 0; i < n && sbq.size() > 0; i++) begin
      s = sbq.pop_front();
      drive(s);
      @(negedge clk);
      check_step(s);
      if (s.exp[10:8] != S_HALT) mc++;
      if ((s.exp[7:0] & F_DONE) != 8'h00) mr++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step_t s;
    rst_n      = 1'b0;
    opcode     = O_R;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    halt_req   = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset state/strobes",
             64'({state, imem_req, dmem_req, ir_write, pc_write, pc_write_cond,
                  instr_done, illegal_op, halted}), 64'({S_IF, 8'h00}));
    check_cnt("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    build(O_R, 0, 0, 1'b0);
    build(O_LW, 0, 2, 1'b0);
    build(O_J, 0, 0, 1'b0);
    build(O_BEQ, 0, 0, 1'b0);
    build(O_BAD, 0, 0, 1'b0);
    build(O_ORI, 2, 0, 1'b0);
    run(1000);

    build(O_ADDI, 0, 0, 1'b1);
    halt_seq(3);
    build(O_SW, 0, 1, 1'b0);
    build(O_LW, 1, 0, 1'b1);
    halt_seq(0);
    build(O_R, 0, 0, 1'b0);
    run(1000);

    // Asynchronous reset in the middle of an SW data access.
    build(O_SW, 0, 3, 1'b0);
    run(3);
    s = sbq.pop_front();
    drive(s);
    #2;
    check_step(s);
    rst_n = 1'b0;
    #1;
    check_eq("mid-reset state/strobes",
             64'({state, imem_req, dmem_req, ir_write, pc_write, pc_write_cond,
                  instr_done, illegal_op, halted}), 64'({S_IF, 8'h00}));
    sbq.delete();
    mc = 0;
    mr = 0;
    check_cnt("mid-reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    build(O_R, 0, 0, 1'b0);
    build(O_SW, 0, 0, 1'b0);
    run(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
